p09_brick_wall: RTL

Brick-wall store and collision source for the breakout game. It holds the alive/dead state of every brick and tracks the raster position with counters. For each active pixel it produces the brick pixel and a `block_collision` strobe for the collision/game-logic stage. At each frame boundary it removes the brick the ball hit, if the game logic confirms the hit through its latched block-collision flag, and refills the wall on game reset or once the wall is cleared.

---
 rtl/p09_brick_wall.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/p09_brick_wall.sv
// Brick-wall store: alive map, raster position counters, brick pixel, collision strobe, frame-boundary removal/refill.
// Latency: brick_pixel/brick_row 1 cycle after pix_x/pix_y; block_collision combinational; score_pulse 1 cycle after frame_pulse.
// Backpressure: none; follows the raster every cycle and acts on the game logic's flags only at frame_pulse.
module p09_brick_wall #(
    parameter int BRICK_COLS = 12,
    parameter int BRICK_ROWS = 6,
    parameter int BRICK_W    = 52,
    parameter int BRICK_H    = 16,
    parameter int WALL_X0    = 8,
    parameter int WALL_Y0    = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [8:0] pix_y,
    input  logic       pix_valid,
    input  logic       ball_pixel,
    input  logic       frame_pulse,
    input  logic       clear_hit,
    input  logic       refill,
    output logic       brick_pixel,
    output logic [2:0] brick_row,
    output logic       block_collision,
    output logic       score_pulse,
    output logic [2:0] score_row,
    output logic [6:0] bricks_left,
    output logic       wall_cleared
);

    localparam int NBRICKS = BRICK_COLS * BRICK_ROWS;
    localparam int CW      = $clog2(BRICK_COLS + 1);
    localparam int XW      = $clog2(BRICK_W);
    localparam int YW      = $clog2(BRICK_H);
    localparam int IW      = $clog2(NBRICKS);

    // raster tracking state
    logic          r_valid_d;
    logic [2:0]    r_row;
    logic [YW-1:0] r_yoff;
    logic          r_row_in;
    logic [CW-1:0] r_col;
    logic [XW-1:0] r_xoff;
    logic          r_col_on;

    // pixel stage
    logic          r_brick_pixel;
    logic [2:0]    r_brick_row;
    logic [CW-1:0] r_pix_col;

    // wall state
    logic [NBRICKS-1:0] r_alive;
    logic [6:0]         r_left;
    logic               r_hit_valid;
    logic [2:0]         r_hit_row;
    logic [CW-1:0]      r_hit_col;
    logic               r_score_pulse;
    logic [2:0]         r_score_row;

    logic [31:0]   w_y32;
    logic [2:0]    w_row_calc;
    logic [YW-1:0] w_yoff_calc;
    logic          w_row_in;
    logic          w_line_start;
    logic          w_x_at0;
    logic [2:0]    w_cur_row;
    logic [YW-1:0] w_cur_yoff;
    logic          w_cur_row_in;
    logic [CW-1:0] w_cur_col;
    logic [XW-1:0] w_cur_xoff;
    logic          w_cur_con;
    logic          w_last_x;
    logic          w_last_col;
    logic          w_face;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_hit_idx;
    logic          w_wall_cleared;

    assign w_y32 = {23'd0, pix_y};

    // Row and line offset from pix_y by comparing against the constant row boundaries (no divider).
    always_comb begin
        w_row_calc  = '0;
        w_yoff_calc = '0;
        w_row_in    = (w_y32 >= 32'(WALL_Y0)) && (w_y32 < 32'(WALL_Y0 + BRICK_ROWS * BRICK_H));
        for (int k = 0; k < BRICK_ROWS; k++) begin
            if (w_y32 >= 32'(WALL_Y0 + k * BRICK_H)) begin
                w_row_calc  = 3'(k);
                w_yoff_calc = YW'(w_y32 - 32'(WALL_Y0 + k * BRICK_H));
            end
        end
    end

    // The first valid pixel of a line uses the freshly computed row; later pixels use the loaded copy.
    assign w_line_start = pix_valid & ~r_valid_d;
    assign w_cur_row    = w_line_start ? w_row_calc  : r_row;
    assign w_cur_yoff   = w_line_start ? w_yoff_calc : r_yoff;
    assign w_cur_row_in = w_line_start ? w_row_in    : r_row_in;

    // Column counters restart at the wall's left edge; a new line drops any stale column run.
    assign w_x_at0    = pix_valid && (pix_x == 10'(WALL_X0));
    assign w_cur_col  = w_x_at0 ? '0 : r_col;
    assign w_cur_xoff = w_x_at0 ? '0 : r_xoff;
    assign w_cur_con  = w_x_at0 | (r_col_on & ~w_line_start);
    assign w_last_x   = (w_cur_xoff == XW'(BRICK_W - 1));
    assign w_last_col = (w_cur_col == CW'(BRICK_COLS - 1));

    assign w_face = pix_valid && w_cur_con && w_cur_row_in &&
                    (w_cur_xoff < XW'(BRICK_W - 1)) && (w_cur_yoff < YW'(BRICK_H - 1));
    assign w_idx     = IW'(32'(w_cur_row) * 32'(BRICK_COLS) + 32'(w_cur_col));
    assign w_hit_idx = IW'(32'(r_hit_row) * 32'(BRICK_COLS) + 32'(r_hit_col));

    assign w_wall_cleared = (r_left == 7'd0);

    // Advance the row/column position counters with the raster.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d <= 1'b0;
            r_row     <= '0;
            r_yoff    <= '0;
            r_row_in  <= 1'b0;
            r_col     <= '0;
            r_xoff    <= '0;
            r_col_on  <= 1'b0;
        end else begin
            r_valid_d <= pix_valid;
            if (w_line_start) begin
                r_row    <= w_row_calc;
                r_yoff   <= w_yoff_calc;
                r_row_in <= w_row_in;
            end
            if (pix_valid) begin
                if (w_cur_con) begin
                    if (w_last_x) begin
                        r_xoff   <= '0;
                        r_col    <= w_cur_col + 1'b1;
                        r_col_on <= ~w_last_col;
                    end else begin
                        r_xoff   <= w_cur_xoff + 1'b1;
                        r_col    <= w_cur_col;
                        r_col_on <= 1'b1;
                    end
                end else begin
                    r_col_on <= 1'b0;
                end
            end
        end
    end

    // Register the brick pixel and its position so collisions name the brick that was drawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brick_pixel <= 1'b0;
            r_brick_row   <= '0;
            r_pix_col     <= '0;
        end else begin
            r_brick_pixel <= w_face & r_alive[w_idx];
            r_brick_row   <= w_cur_row;
            r_pix_col     <= w_cur_col;
        end
    end

    // Capture the first hit of a frame; apply refill or removal only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alive       <= '1;
            r_left        <= 7'(NBRICKS);
            r_hit_valid   <= 1'b0;
            r_hit_row     <= '0;
            r_hit_col     <= '0;
            r_score_pulse <= 1'b0;
            r_score_row   <= '0;
        end else begin
            r_score_pulse <= 1'b0;
            if (frame_pulse) begin
                r_hit_valid <= 1'b0;
                if (refill || w_wall_cleared) begin
                    r_alive <= '1;
                    r_left  <= 7'(NBRICKS);
                end else if (clear_hit && r_hit_valid && r_alive[w_hit_idx]) begin
                    r_alive[w_hit_idx] <= 1'b0;
                    r_left             <= r_left - 1'b1;
                    r_score_pulse      <= 1'b1;
                    r_score_row        <= r_hit_row;
                end
            end else if (block_collision && !r_hit_valid) begin
                r_hit_valid <= 1'b1;
                r_hit_row   <= r_brick_row;
                r_hit_col   <= r_pix_col;
            end
        end
    end

    assign brick_pixel     = r_brick_pixel;
    assign brick_row       = r_brick_row;
    assign block_collision = r_brick_pixel & ball_pixel;
    assign score_pulse     = r_score_pulse;
    assign score_row       = r_score_row;
    assign bricks_left     = r_left;
    assign wall_cleared    = w_wall_cleared;

endmodule
